mips32_id_stage: RTL

- Instruction-decode stage of the MIPS32 pipeline. It takes fetched instruction words, reads operands from an internal 32x32 register file, and sign-extends immediates.
- It registers everything the EX-stage ALU consumes: operand A, operand B, and the 6-bit function code, which equals the opcode.
- It also owns the register-file write port driven by WB and a sticky halt.

---
 rtl/mips32_id_stage.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mips32_id_stage.sv
// Purpose: MIPS32 instruction decode with 32x32 register file, WB write port and sticky halt.
// Latency: 1 cycle from instruction accept to ex_valid; register-file writes bypass same-cycle reads.
// Backpressure: valid/ready; ID/EX register holds while ex_ready=0; flush kills held and incoming work.
module mips32_id_stage #(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_valid,
    output logic          if_ready,
    input  logic [DW-1:0] if_instr,
    input  logic [DW-1:0] if_npc,
    input  logic          flush,
    input  logic          wb_en,
    input  logic [4:0]    wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          ex_valid,
    input  logic          ex_ready,
    output logic [DW-1:0] ex_a1,
    output logic [DW-1:0] ex_a2,
    output logic [5:0]    ex_fun,
    output logic [2:0]    ex_type,
    output logic [4:0]    ex_rd,
    output logic [DW-1:0] ex_sdata,
    output logic          ex_rs_zero,
    output logic          halted
);

    typedef enum logic [2:0] {
        T_RR    = 3'd0,
        T_RM    = 3'd1,
        T_LOAD  = 3'd2,
        T_STORE = 3'd3,
        T_BR    = 3'd4,
        T_HALT  = 3'd5,
        T_ILL   = 3'd7
    } itype_e;

    // Architectural register file; entry 0 is never written.
    logic [DW-1:0] r_regs [NREG];

    // ID/EX pipeline register
    logic          r_ex_valid;
    logic [DW-1:0] r_ex_a1;
    logic [DW-1:0] r_ex_a2;
    logic [5:0]    r_ex_fun;
    itype_e        r_ex_type;
    logic [4:0]    r_ex_rd;
    logic [DW-1:0] r_ex_sdata;
    logic          r_ex_rs_zero;
    logic          r_halted;

    // Instruction fields
    logic [5:0]    w_op;
    logic [4:0]    w_rs;
    logic [4:0]    w_rt;
    logic [4:0]    w_rdf;
    logic [DW-1:0] w_simm;
    logic [DW-1:0] w_rs_val;
    logic [DW-1:0] w_rt_val;

    // Decoded results
    itype_e        w_type;
    logic [DW-1:0] w_a1;
    logic [DW-1:0] w_a2;
    logic [4:0]    w_rd;
    logic          w_load;

    assign w_op   = if_instr[31:26];
    assign w_rs   = if_instr[25:21];
    assign w_rt   = if_instr[20:16];
    assign w_rdf  = if_instr[15:11];
    assign w_simm = {{(DW-16){if_instr[15]}}, if_instr[15:0]};

    // Operand reads: R0 is hard zero, and a write landing this cycle is forwarded.
    always_comb begin
        w_rs_val = r_regs[w_rs];
        w_rt_val = r_regs[w_rt];
        if (wb_en && (wb_addr == w_rs)) w_rs_val = wb_data;
        if (wb_en && (wb_addr == w_rt)) w_rt_val = wb_data;
        if (w_rs == 5'd0) w_rs_val = '0;
        if (w_rt == 5'd0) w_rt_val = '0;
    end

    // Opcode decode into instruction class, ALU operands and destination.
    always_comb begin
        w_type = T_ILL;
        w_a1   = '0;
        w_a2   = '0;
        w_rd   = 5'd0;
        case (w_op)
            6'b000000, 6'b000001, 6'b000010,
            6'b000011, 6'b000100, 6'b000101: begin
                w_type = T_RR;
                w_a1   = w_rs_val;
                w_a2   = w_rt_val;
                w_rd   = w_rdf;
            end
            6'b001010, 6'b001011, 6'b001100: begin
                w_type = T_RM;
                w_a1   = w_rs_val;
                w_a2   = w_simm;
                w_rd   = w_rt;
            end
            6'b001000: begin
                w_type = T_LOAD;
                w_a1   = w_rs_val;
                w_a2   = w_simm;
                w_rd   = w_rt;
            end
            6'b001001: begin
                w_type = T_STORE;
                w_a1   = w_rs_val;
                w_a2   = w_simm;
            end
            // Branch target is npc + offset, computed by the ALU as an add.
            6'b001101, 6'b001110: begin
                w_type = T_BR;
                w_a1   = if_npc;
                w_a2   = w_simm;
            end
            6'b111111: begin
                w_type = T_HALT;
            end
            default: begin
                w_type = T_ILL;
            end
        endcase
    end

    assign if_ready = !r_halted && (!r_ex_valid || ex_ready);
    assign w_load   = if_valid && if_ready && !flush;

    // Register file write port; WB writes are never blocked by halt or flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (wb_en && (wb_addr != 5'd0)) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    // ID/EX register: flush beats load, load beats drain, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid   <= 1'b0;
            r_ex_a1      <= '0;
            r_ex_a2      <= '0;
            r_ex_fun     <= 6'd0;
            r_ex_type    <= T_RR;
            r_ex_rd      <= 5'd0;
            r_ex_sdata   <= '0;
            r_ex_rs_zero <= 1'b0;
            r_halted     <= 1'b0;
        end else if (flush) begin
            r_ex_valid <= 1'b0;
        end else if (w_load) begin
            r_ex_valid   <= 1'b1;
            r_ex_a1      <= w_a1;
            r_ex_a2      <= w_a2;
            r_ex_fun     <= w_op;
            r_ex_type    <= w_type;
            r_ex_rd      <= w_rd;
            r_ex_sdata   <= w_rt_val;
            r_ex_rs_zero <= (w_rs_val == '0);
            if (w_type == T_HALT) r_halted <= 1'b1;
        end else if (ex_ready) begin
            r_ex_valid <= 1'b0;
        end
    end

    assign ex_valid   = r_ex_valid;
    assign ex_a1      = r_ex_a1;
    assign ex_a2      = r_ex_a2;
    assign ex_fun     = r_ex_fun;
    assign ex_type    = r_ex_type;
    assign ex_rd      = r_ex_rd;
    assign ex_sdata   = r_ex_sdata;
    assign ex_rs_zero = r_ex_rs_zero;
    assign halted     = r_halted;

endmodule
